// File: rtl/tcdm_bank_rr_arbiter_pkg.sv
// Shared constants and helpers for the TCDM per-bank round-robin arbiter.
package tcdm_arb_pkg;

    localparam int unsigned PERF_CNT_W = 32;

    // Index width for an n-entry vector, never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcdm_bank_rr_arbiter_if.sv
// Initiator-side and bank-side signals of one TCDM bank arbiter.
interface tcdm_bank_rr_arbiter_if #(
    parameter int unsigned NbIn      = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8,
    parameter int unsigned IdWidth   = 1
);

    logic [NbIn-1:0]                in_req_i;
    logic [NbIn-1:0][AddrWidth-1:0] in_add_i;
    logic [NbIn-1:0]                in_wen_i;
    logic [NbIn-1:0][DataWidth-1:0] in_data_i;
    logic [NbIn-1:0][BeWidth-1:0]   in_be_i;
    logic [NbIn-1:0][IdWidth-1:0]   in_id_i;
    logic [NbIn-1:0]                in_gnt_o;
    logic [NbIn-1:0]                in_r_valid_o;
    logic [DataWidth-1:0]           in_r_data_o;
    logic [IdWidth-1:0]             in_r_id_o;

    logic                           bank_req_o;
    logic [AddrWidth-1:0]           bank_add_o;
    logic                           bank_wen_o;
    logic [DataWidth-1:0]           bank_data_o;
    logic [BeWidth-1:0]             bank_be_o;
    logic [IdWidth-1:0]             bank_id_o;
    logic                           bank_gnt_i;
    logic [DataWidth-1:0]           bank_r_data_i;
    logic [IdWidth-1:0]             bank_r_id_i;

    // Arbiter view
    modport slave (
        input  in_req_i, in_add_i, in_wen_i, in_data_i, in_be_i, in_id_i,
        output in_gnt_o, in_r_valid_o, in_r_data_o, in_r_id_o,
        output bank_req_o, bank_add_o, bank_wen_o, bank_data_o, bank_be_o, bank_id_o,
        input  bank_gnt_i, bank_r_data_i, bank_r_id_i
    );

    // Environment view: initiators plus bank
    modport master (
        output in_req_i, in_add_i, in_wen_i, in_data_i, in_be_i, in_id_i,
        input  in_gnt_o, in_r_valid_o, in_r_data_o, in_r_id_o,
        input  bank_req_o, bank_add_o, bank_wen_o, bank_data_o, bank_be_o, bank_id_o,
        output bank_gnt_i, bank_r_data_i, bank_r_id_i
    );

endinterface

// File: rtl/tcdm_bank_rr_arbiter_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr_i, wrapping.
module tcdm_rr_pick #(
    parameter int unsigned NbIn = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [NbIn-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [NbIn-1:0] gnt_c,
    output logic [IdxW-1:0] idx_c,
    output logic            any_c
);

    logic            found;
    logic [IdxW-1:0] cand;

    // Scan NbIn positions starting at the pointer; keep the first hit
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NbIn; k++) begin
            cand = IdxW'((32'(ptr_i) + k) % NbIn);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_c = cand;
            end
        end
        if (found) begin
            gnt_c[idx_c] = 1'b1;
        end
        any_c = |req_i;
    end

endmodule

// File: rtl/tcdm_bank_rr_arbiter.sv
// Round-robin arbiter in front of one TCDM bank; routes the 1-cycle response
// back to the registered winner. Optional conflict counter: TCDM_ARB_PERF_CNT_EN.
module tcdm_bank_rr_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int unsigned NbIn      = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8,
    parameter int unsigned IdWidth   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    tcdm_bank_rr_arbiter_if.slave   bus,
    input  logic                    perf_clr_i,
    output logic [PERF_CNT_W-1:0]   perf_conflicts_o
);

    localparam int unsigned IdxW = idx_width(NbIn);

    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] rr_ptr_d;
    logic [IdxW-1:0] win_idx;
    logic [NbIn-1:0] win_gnt;
    logic            any_req;
    logic            hs;
    logic            resp_valid_q;
    logic [IdxW-1:0] resp_idx_q;

    tcdm_rr_pick #(
        .NbIn (NbIn),
        .IdxW (IdxW)
    ) i_pick (
        .req_i (bus.in_req_i),
        .ptr_i (rr_ptr_q),
        .gnt_c (win_gnt),
        .idx_c (win_idx),
        .any_c (any_req)
    );

    // Request path: winner fields to the bank, grant forwarded to the winner only
    assign bus.bank_req_o  = any_req;
    assign bus.bank_add_o  = bus.in_add_i[win_idx];
    assign bus.bank_wen_o  = bus.in_wen_i[win_idx];
    assign bus.bank_data_o = bus.in_data_i[win_idx];
    assign bus.bank_be_o   = bus.in_be_i[win_idx];
    assign bus.bank_id_o   = bus.in_id_i[win_idx];
    assign bus.in_gnt_o    = win_gnt & {NbIn{bus.bank_gnt_i}};

    assign hs       = any_req & bus.bank_gnt_i;
    assign rr_ptr_d = (32'(win_idx) == NbIn - 1) ? '0 : win_idx + IdxW'(1);

    // Priority pointer moves past the winner on every handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (hs) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Remember who owns the response arriving next cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_idx_q   <= '0;
        end else begin
            resp_valid_q <= hs;
            if (hs) begin
                resp_idx_q <= win_idx;
            end
        end
    end

    // Response valid steered to the recorded winner; data and id broadcast
    always_comb begin
        bus.in_r_valid_o             = '0;
        bus.in_r_valid_o[resp_idx_q] = resp_valid_q;
    end

    assign bus.in_r_data_o = bus.bank_r_data_i;
    assign bus.in_r_id_o   = bus.bank_r_id_i;

`ifdef TCDM_ARB_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] perf_q;
    logic                  conflict;

    assign conflict = hs && ($countones(bus.in_req_i) >= 2);

    // Saturating count of handshakes that left another requester waiting
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (perf_clr_i) begin
            perf_q <= '0;
        end else if (conflict && (perf_q != '1)) begin
            perf_q <= perf_q + PERF_CNT_W'(1);
        end
    end

    assign perf_conflicts_o = perf_q;
`else
    logic unused_perf_clr;

    assign unused_perf_clr  = perf_clr_i;
    assign perf_conflicts_o = '0;
`endif

endmodule

// File: tb/tb_tcdm_bank_rr_arbiter.sv
// Self-checking bench for tcdm_bank_rr_arbiter: directed plan steps then random traffic
// against a round-robin reference model.
module tb_tcdm_bank_rr_arbiter;

    localparam int unsigned NB = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned IW = 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          perf_clr_i = 1'b0;
    logic [31:0]   perf_conflicts_o;

    tcdm_bank_rr_arbiter_if #(
        .NbIn (NB), .AddrWidth (AW), .DataWidth (DW), .BeWidth (BW), .IdWidth (IW)
    ) bus ();

    tcdm_bank_rr_arbiter #(
        .NbIn (NB), .AddrWidth (AW), .DataWidth (DW), .BeWidth (BW), .IdWidth (IW)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .bus              (bus),
        .perf_clr_i       (perf_clr_i),
        .perf_conflicts_o (perf_conflicts_o)
    );

    always #5 clk_i = ~clk_i;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model state
    int          m_ptr  = 0;
    bit          m_rv   = 0;
    int          m_ridx = 0;
    logic [31:0] m_perf = '0;

    // Bench copies of driven stimulus
    logic [AW-1:0] t_add  [NB];
    logic          t_wen  [NB];
    logic [DW-1:0] t_data [NB];
    logic [BW-1:0] t_be   [NB];
    logic [IW-1:0] t_id   [NB];
    logic [DW-1:0] t_rdata;
    logic [IW-1:0] t_rid;

    int          ovr_port = -1;
    logic [31:0] ovr_add  = '0;

    // Observations of the last cycle for directed checks
    logic [NB-1:0] obs_gnt;
    logic [NB-1:0] obs_rv;
    logic [AW-1:0] obs_add;
    logic [DW-1:0] obs_rdata;
    logic [31:0]   obs_perf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_rv   = 0;
        m_ridx = 0;
        m_perf = '0;
    endtask

    // One clock: drive at negedge, check all outputs against the model, step the model
    task automatic cycle(input logic [NB-1:0] req, input logic gnt, input logic clr);
        int            w;
        bit            f;
        bit            hs;
        int            idx;
        logic [NB-1:0] eg;
        logic [NB-1:0] erv;
        @(negedge clk_i);
        for (int i = 0; i < NB; i++) begin
            t_add[i]  = $urandom;
            t_wen[i]  = 1'($urandom);
            t_data[i] = $urandom;
            t_be[i]   = BW'($urandom);
            t_id[i]   = IW'($urandom);
        end
        if (ovr_port >= 0) begin
            t_add[ovr_port] = ovr_add;
            t_wen[ovr_port] = 1'b1;
        end
        for (int i = 0; i < NB; i++) begin
            bus.in_add_i[i]  = t_add[i];
            bus.in_wen_i[i]  = t_wen[i];
            bus.in_data_i[i] = t_data[i];
            bus.in_be_i[i]   = t_be[i];
            bus.in_id_i[i]   = t_id[i];
        end
        t_rdata = $urandom;
        t_rid   = IW'($urandom);
        bus.in_req_i      = req;
        bus.bank_gnt_i    = gnt;
        bus.bank_r_data_i = t_rdata;
        bus.bank_r_id_i   = t_rid;
        perf_clr_i        = clr;
        #1;
        w = 0;
        f = 0;
        for (int k = 0; k < NB; k++) begin
            idx = (m_ptr + k) % NB;
            if (!f && req[idx]) begin
                f = 1;
                w = idx;
            end
        end
        hs = f && gnt;
        eg = '0;
        if (hs) eg[w] = 1'b1;
        chk("in_gnt", 64'(bus.in_gnt_o), 64'(eg));
        chk("bank_req", 64'(bus.bank_req_o), 64'(f));
        chk("bank_add", 64'(bus.bank_add_o), 64'(t_add[w]));
        chk("bank_wen", 64'(bus.bank_wen_o), 64'(t_wen[w]));
        chk("bank_data", 64'(bus.bank_data_o), 64'(t_data[w]));
        chk("bank_be", 64'(bus.bank_be_o), 64'(t_be[w]));
        chk("bank_id", 64'(bus.bank_id_o), 64'(t_id[w]));
        erv = '0;
        if (m_rv) erv[m_ridx] = 1'b1;
        chk("r_valid", 64'(bus.in_r_valid_o), 64'(erv));
        if (m_rv) begin
            chk("r_data", 64'(bus.in_r_data_o), 64'(t_rdata));
            chk("r_id", 64'(bus.in_r_id_o), 64'(t_rid));
        end
        chk("perf", 64'(perf_conflicts_o), 64'(m_perf));
        obs_gnt   = bus.in_gnt_o;
        obs_rv    = bus.in_r_valid_o;
        obs_add   = bus.bank_add_o;
        obs_rdata = bus.in_r_data_o;
        obs_perf  = perf_conflicts_o;
        @(posedge clk_i);
        if (hs) begin
            m_ptr  = (w + 1) % NB;
            m_ridx = w;
        end
        m_rv = hs;
`ifdef TCDM_ARB_PERF_CNT_EN
        if (clr) m_perf = '0;
        else if (hs && ($countones(req) >= 2) && (m_perf != 32'hFFFF_FFFF)) m_perf = m_perf + 32'd1;
`endif
    endtask

    // Reset asserted at a negedge; outputs checked while reset is active
    task automatic do_reset();
        @(negedge clk_i);
        rst_ni         = 1'b0;
        bus.in_req_i   = '0;
        bus.bank_gnt_i = 1'b1;
        perf_clr_i     = 1'b0;
        #1;
        chk("rst_in_gnt", 64'(bus.in_gnt_o), 64'h0);
        chk("rst_r_valid", 64'(bus.in_r_valid_o), 64'h0);
        chk("rst_bank_req", 64'(bus.bank_req_o), 64'h0);
        chk("rst_perf", 64'(perf_conflicts_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.in_req_i      = '0;
        bus.in_add_i      = '0;
        bus.in_wen_i      = '0;
        bus.in_data_i     = '0;
        bus.in_be_i       = '0;
        bus.in_id_i       = '0;
        bus.bank_gnt_i    = 1'b0;
        bus.bank_r_data_i = '0;
        bus.bank_r_id_i   = '0;

        do_reset();

        // Single read from port 2 at 0x40
        ovr_port = 2;
        ovr_add  = 32'h40;
        cycle(4'b0100, 1'b1, 1'b0);
        ovr_port = -1;
        chk("single_gnt", 64'(obs_gnt), 64'b0100);
        chk("single_add", 64'(obs_add), 64'h40);
        cycle(4'b0000, 1'b1, 1'b0);
        chk("single_rv", 64'(obs_rv), 64'b0100);
        chk("single_rdata", 64'(obs_rdata), 64'(t_rdata));

        // Pointer at 3: port 3 wins, then wrap to port 0
        cycle(4'b1001, 1'b1, 1'b0);
        chk("wrap_gnt3", 64'(obs_gnt), 64'b1000);
        cycle(4'b1001, 1'b1, 1'b0);
        chk("wrap_gnt0", 64'(obs_gnt), 64'b0001);

        // All four requesting from reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            chk("all4_gnt", 64'(obs_gnt), 64'(4'b0001 << (i % 4)));
            if (i > 0) chk("all4_rv", 64'(obs_rv), 64'(4'b0001 << ((i - 1) % 4)));
        end
        cycle(4'b0000, 1'b1, 1'b0);
        chk("all4_last_rv", 64'(obs_rv), 64'b1000);
`ifdef TCDM_ARB_PERF_CNT_EN
        chk("all4_perf", 64'(obs_perf), 64'd8);
`endif

        // Bank stall: no grant, no response; pointer port served first afterwards
        cycle(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0011, 1'b0, 1'b0);
            chk("stall_gnt", 64'(obs_gnt), 64'h0);
            if (i > 0) chk("stall_rv", 64'(obs_rv), 64'h0);
        end
        cycle(4'b0011, 1'b1, 1'b0);
        chk("stall_resume_gnt", 64'(obs_gnt), 64'b0010);

        // Reset right after a handshake drops the pending response
        cycle(4'b0100, 1'b1, 1'b0);
        do_reset();
        cycle(4'b1111, 1'b1, 1'b0);
        chk("post_rst_gnt", 64'(obs_gnt), 64'b0001);
        chk("post_rst_rv", 64'(obs_rv), 64'h0);

`ifdef TCDM_ARB_PERF_CNT_EN
        // Clear wins over a simultaneous conflict
        cycle(4'b1111, 1'b1, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0);
        chk("perf_clr", 64'(obs_perf), 64'h0);
        // Saturation near the top
        @(negedge clk_i);
        bus.in_req_i = '0;
        dut.perf_q   = 32'hFFFF_FFFE;
        m_perf       = 32'hFFFF_FFFE;
        m_rv         = 0;
        for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        chk("perf_sat", 64'(obs_perf), 64'hFFFF_FFFF);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(NB'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end

`ifndef TCDM_ARB_PERF_CNT_EN
        chk("perf_off", 64'(perf_conflicts_o), 64'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
